// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared owner/state types for the three-port SDRAM arbiter
package sdram_arb_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_VIDEO, OWN_CPU, OWN_DMA} owner_t;
    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DRAIN} state_t;
endpackage

// File: rtl/sdram_rr_picker.sv
// sdram_rr_picker: 2-way CPU/DMA round-robin pick with registered last-served owner
//   clk_i, rst_n_i         clock, async active-low reset
//   cpu_req, dma_req       pending requests
//   done, done_owner       transaction finished and who owned it (video is ignored)
//   pick                   OWN_CPU, OWN_DMA or OWN_NONE
module sdram_rr_picker
    import sdram_arb_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  logic   cpu_req,
    input  logic   dma_req,
    input  logic   done,
    input  owner_t done_owner,
    output owner_t pick
);
    owner_t rr_last;
    // Starting from DMA makes CPU win the first tie
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) rr_last <= OWN_DMA;
        else if (done && (done_owner == OWN_CPU || done_owner == OWN_DMA)) rr_last <= done_owner;
    assign pick = cpu_req && dma_req ? (rr_last == OWN_CPU ? OWN_DMA : OWN_CPU) :
                  cpu_req ? OWN_CPU : dma_req ? OWN_DMA : OWN_NONE;
endmodule

// File: rtl/sdram_three_port_arbiter.sv
// sdram_three_port_arbiter: shares one sdram_pnru port between video, CPU and DMA
//   sdram_*        controller side: rd/wr/addr/wdata/wmask/burst out, ack/rdy/rdata in
//   video_sdram_*  burst-read requester, fixed highest priority
//   cpu_sdram_*    single-word requester, round-robin with DMA
//   dma_sdram_*    single-word requester, round-robin with CPU
//   grant_o        current owner: 0 none, 1 video, 2 cpu, 3 dma
module sdram_three_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int VIDEO_BURST_LEN = 4,
    parameter int ADDR_W          = 24
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    output logic              sdram_rd,
    output logic              sdram_wr,
    output logic [ADDR_W-1:0] sdram_addr_x16,
    output logic [15:0]       sdram_wdata,
    output logic [1:0]        sdram_wmask,
    output logic              sdram_burst,
    input  logic              sdram_ack,
    input  logic              sdram_rdy,
    input  logic [15:0]       sdram_rdata,
    input  logic              cpu_sdram_rd,
    input  logic              cpu_sdram_wr,
    input  logic [ADDR_W-1:0] cpu_sdram_addr_x16,
    input  logic [15:0]       cpu_sdram_wdata,
    input  logic [1:0]        cpu_sdram_wmask,
    output logic              cpu_sdram_ack,
    output logic              cpu_sdram_rdy,
    output logic [15:0]       cpu_sdram_rdata,
    input  logic              dma_sdram_rd,
    input  logic              dma_sdram_wr,
    input  logic [ADDR_W-1:0] dma_sdram_addr_x16,
    input  logic [15:0]       dma_sdram_wdata,
    input  logic [1:0]        dma_sdram_wmask,
    output logic              dma_sdram_ack,
    output logic              dma_sdram_rdy,
    output logic [15:0]       dma_sdram_rdata,
    input  logic              video_sdram_rd,
    input  logic [ADDR_W-1:0] video_sdram_addr_x16,
    output logic              video_sdram_ack,
    output logic              video_sdram_rdy,
    output logic [15:0]       video_sdram_rdata,
    output logic [1:0]        grant_o
);
    localparam int CNT_W = $clog2(VIDEO_BURST_LEN + 1);

    state_t            state;
    owner_t            owner;
    owner_t            rr_pick;
    owner_t            winner;
    logic [CNT_W-1:0]  cnt;
    logic              own_rd, own_wr, in_cmd, ack_hit, beat, done;
    logic [ADDR_W-1:0] own_addr;
    logic [15:0]       own_wdata;
    logic [1:0]        own_wmask;

    always_comb begin
        own_rd    = owner == OWN_VIDEO ? video_sdram_rd : owner == OWN_CPU ? cpu_sdram_rd :
                    owner == OWN_DMA ? dma_sdram_rd : 1'b0;
        own_wr    = owner == OWN_CPU ? cpu_sdram_wr : owner == OWN_DMA ? dma_sdram_wr : 1'b0;
        own_addr  = owner == OWN_VIDEO ? video_sdram_addr_x16 : owner == OWN_CPU ? cpu_sdram_addr_x16 :
                    owner == OWN_DMA ? dma_sdram_addr_x16 : '0;
        own_wdata = owner == OWN_CPU ? cpu_sdram_wdata : owner == OWN_DMA ? dma_sdram_wdata : '0;
        own_wmask = owner == OWN_CPU ? cpu_sdram_wmask : owner == OWN_DMA ? dma_sdram_wmask : '0;
    end

    assign in_cmd  = state == ST_CMD;
    assign ack_hit = in_cmd & sdram_ack;
    // Beats beyond the loaded count are dropped so the counter never wraps
    assign beat    = state == ST_DRAIN & sdram_rdy & cnt != '0;
    assign done    = (ack_hit & ~own_rd) | (beat & cnt == CNT_W'(1));
    assign winner  = video_sdram_rd ? OWN_VIDEO : rr_pick;

    // Read takes precedence when a requester raises both strobes
    assign sdram_rd       = in_cmd & own_rd;
    assign sdram_wr       = in_cmd & own_wr & ~own_rd;
    assign sdram_addr_x16 = in_cmd ? own_addr : '0;
    assign sdram_wdata    = in_cmd ? own_wdata : '0;
    assign sdram_wmask    = in_cmd ? own_wmask : '0;
    assign sdram_burst    = in_cmd & owner == OWN_VIDEO;

    assign video_sdram_ack = ack_hit & owner == OWN_VIDEO;
    assign cpu_sdram_ack   = ack_hit & owner == OWN_CPU;
    assign dma_sdram_ack   = ack_hit & owner == OWN_DMA;
    assign video_sdram_rdy = beat & owner == OWN_VIDEO;
    assign cpu_sdram_rdy   = beat & owner == OWN_CPU;
    assign dma_sdram_rdy   = beat & owner == OWN_DMA;

    assign video_sdram_rdata = sdram_rdata;
    assign cpu_sdram_rdata   = sdram_rdata;
    assign dma_sdram_rdata   = sdram_rdata;
    assign grant_o           = owner;

    sdram_rr_picker u_rr (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .cpu_req    (cpu_sdram_rd | cpu_sdram_wr),
        .dma_req    (dma_sdram_rd | dma_sdram_wr),
        .done       (done),
        .done_owner (owner),
        .pick       (rr_pick)
    );

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) begin
            state <= ST_IDLE;
            owner <= OWN_NONE;
            cnt   <= '0;
        end else
            case (state)
                ST_IDLE:
                    if (winner != OWN_NONE) begin
                        owner <= winner;
                        state <= ST_CMD;
                    end
                ST_CMD:
                    if (sdram_ack) begin
                        if (own_rd) begin
                            cnt   <= owner == OWN_VIDEO ? CNT_W'(VIDEO_BURST_LEN) : CNT_W'(1);
                            state <= ST_DRAIN;
                        end else begin
                            owner <= OWN_NONE;
                            state <= ST_IDLE;
                        end
                    end
                ST_DRAIN:
                    if (beat) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            owner <= OWN_NONE;
                            state <= ST_IDLE;
                        end
                    end
                default: state <= ST_IDLE;
            endcase

    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_n_i) in_cmd |-> (own_rd | own_wr));
    a_rdy_drain: assert property (@(posedge clk_i) disable iff (!rst_n_i) sdram_rdy |-> state == ST_DRAIN);
    a_ack_cmd: assert property (@(posedge clk_i) disable iff (!rst_n_i) sdram_ack |-> in_cmd);
endmodule

// File: tb/tb_sdram_three_port_arbiter.sv
// tb_sdram_three_port_arbiter: directed and random checks of the three-port SDRAM arbiter
module tb_sdram_three_port_arbiter;
    localparam int VB = 4;

    logic        clk_i, rst_n_i;
    logic        sdram_rd, sdram_wr, sdram_burst;
    logic [23:0] sdram_addr_x16;
    logic [15:0] sdram_wdata, sdram_rdata;
    logic [1:0]  sdram_wmask, grant_o;
    logic        sdram_ack, sdram_rdy;
    logic        cpu_sdram_rd, cpu_sdram_wr, cpu_sdram_ack, cpu_sdram_rdy;
    logic [23:0] cpu_sdram_addr_x16;
    logic [15:0] cpu_sdram_wdata, cpu_sdram_rdata;
    logic [1:0]  cpu_sdram_wmask;
    logic        dma_sdram_rd, dma_sdram_wr, dma_sdram_ack, dma_sdram_rdy;
    logic [23:0] dma_sdram_addr_x16;
    logic [15:0] dma_sdram_wdata, dma_sdram_rdata;
    logic [1:0]  dma_sdram_wmask;
    logic        video_sdram_rd, video_sdram_ack, video_sdram_rdy;
    logic [23:0] video_sdram_addr_x16;
    logic [15:0] video_sdram_rdata;

    int          checks = 0, passes = 0, fails = 0;
    int          lat;
    int          last_cd;
    logic        dma_on_last;
    logic [15:0] beat_q[$];

    sdram_three_port_arbiter #(.VIDEO_BURST_LEN(VB), .ADDR_W(24)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_addr_x16(sdram_addr_x16),
        .sdram_wdata(sdram_wdata), .sdram_wmask(sdram_wmask), .sdram_burst(sdram_burst),
        .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy), .sdram_rdata(sdram_rdata),
        .cpu_sdram_rd(cpu_sdram_rd), .cpu_sdram_wr(cpu_sdram_wr), .cpu_sdram_addr_x16(cpu_sdram_addr_x16),
        .cpu_sdram_wdata(cpu_sdram_wdata), .cpu_sdram_wmask(cpu_sdram_wmask),
        .cpu_sdram_ack(cpu_sdram_ack), .cpu_sdram_rdy(cpu_sdram_rdy), .cpu_sdram_rdata(cpu_sdram_rdata),
        .dma_sdram_rd(dma_sdram_rd), .dma_sdram_wr(dma_sdram_wr), .dma_sdram_addr_x16(dma_sdram_addr_x16),
        .dma_sdram_wdata(dma_sdram_wdata), .dma_sdram_wmask(dma_sdram_wmask),
        .dma_sdram_ack(dma_sdram_ack), .dma_sdram_rdy(dma_sdram_rdy), .dma_sdram_rdata(dma_sdram_rdata),
        .video_sdram_rd(video_sdram_rd), .video_sdram_addr_x16(video_sdram_addr_x16),
        .video_sdram_ack(video_sdram_ack), .video_sdram_rdy(video_sdram_rdy), .video_sdram_rdata(video_sdram_rdata),
        .grant_o(grant_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] own_vec(input logic [1:0] o);
        return o == 2'd1 ? 3'b100 : o == 2'd2 ? 3'b010 : o == 2'd3 ? 3'b001 : 3'b000;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 32'({sdram_rd, sdram_wr, sdram_burst, sdram_wmask, video_sdram_ack, cpu_sdram_ack,
                               dma_sdram_ack, video_sdram_rdy, cpu_sdram_rdy, dma_sdram_rdy, grant_o}), 32'd0);
        chk({tag, "_addr"}, 32'(sdram_addr_x16), 32'd0);
        chk({tag, "_wdata"}, 32'(sdram_wdata), 32'd0);
    endtask

    task automatic clear_inputs();
        sdram_ack = 0; sdram_rdy = 0; sdram_rdata = 0;
        cpu_sdram_rd = 0; cpu_sdram_wr = 0; cpu_sdram_addr_x16 = 0; cpu_sdram_wdata = 0; cpu_sdram_wmask = 0;
        dma_sdram_rd = 0; dma_sdram_wr = 0; dma_sdram_addr_x16 = 0; dma_sdram_wdata = 0; dma_sdram_wmask = 0;
        video_sdram_rd = 0; video_sdram_addr_x16 = 0;
    endtask

    task automatic do_reset();
        rst_n_i = 0;
        clear_inputs();
        last_cd = 3;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1;
        @(negedge clk_i);
    endtask

    task automatic raise_cpu();
        int op;
        op = $urandom_range(0, 3);
        cpu_sdram_rd = op == 0 || op == 3;
        cpu_sdram_wr = op != 0;
        cpu_sdram_addr_x16 = 24'($urandom);
        cpu_sdram_wdata = 16'($urandom);
        cpu_sdram_wmask = 2'($urandom);
    endtask

    task automatic raise_dma();
        int op;
        op = $urandom_range(0, 3);
        dma_sdram_rd = op == 0 || op == 3;
        dma_sdram_wr = op != 0;
        dma_sdram_addr_x16 = 24'($urandom);
        dma_sdram_wdata = 16'($urandom);
        dma_sdram_wmask = 2'($urandom);
    endtask

    // Plays the controller for one transaction granted to exp; stop_after >= 0 abandons the read after that many beats
    task automatic serve(input logic [1:0] exp, input int stop_after);
        int          n, nb;
        logic        rd, wr;
        logic [23:0] a;
        logic [15:0] wd, d;
        logic [1:0]  wm;
        rd = exp == 2'd1 ? video_sdram_rd : exp == 2'd2 ? cpu_sdram_rd : dma_sdram_rd;
        wr = exp == 2'd1 ? 1'b0 : exp == 2'd2 ? cpu_sdram_wr : dma_sdram_wr;
        a  = exp == 2'd1 ? video_sdram_addr_x16 : exp == 2'd2 ? cpu_sdram_addr_x16 : dma_sdram_addr_x16;
        wd = exp == 2'd2 ? cpu_sdram_wdata : dma_sdram_wdata;
        wm = exp == 2'd1 ? 2'b00 : exp == 2'd2 ? cpu_sdram_wmask : dma_sdram_wmask;
        n = 0;
        @(negedge clk_i);
        while (!(sdram_rd || sdram_wr) && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        lat = n;
        chk("cmd_seen", 32'(sdram_rd | sdram_wr), 32'd1);
        if (!(sdram_rd || sdram_wr)) return;
        chk("grant", 32'(grant_o), 32'(exp));
        chk("sdram_rd", 32'(sdram_rd), 32'(rd));
        chk("sdram_wr", 32'(sdram_wr), 32'(wr & ~rd));
        chk("addr", 32'(sdram_addr_x16), 32'(a));
        chk("burst", 32'(sdram_burst), 32'(exp == 2'd1));
        chk("wmask", 32'(sdram_wmask), 32'(wm));
        if (wr && !rd) chk("wdata", 32'(sdram_wdata), 32'(wd));
        sdram_ack = 1;
        #1;
        chk("ack_route", 32'({video_sdram_ack, cpu_sdram_ack, dma_sdram_ack}), 32'(own_vec(exp)));
        @(posedge clk_i);
        #1;
        sdram_ack = 0;
        if (exp == 2'd1) video_sdram_rd = 0;
        if (exp == 2'd2) begin cpu_sdram_rd = 0; cpu_sdram_wr = 0; end
        if (exp == 2'd3) begin dma_sdram_rd = 0; dma_sdram_wr = 0; end
        @(negedge clk_i);
        chk("cmd_off", 32'({sdram_rd, sdram_wr}), 32'd0);
        if (rd) begin
            nb = exp == 2'd1 ? VB : 1;
            for (int i = 0; i < nb && i != stop_after; i++) begin
                repeat ($urandom_range(0, 1)) @(negedge clk_i);
                d = beat_q.size() > 0 ? beat_q.pop_front() : 16'($urandom);
                if (dma_on_last && i == nb - 1) begin
                    dma_sdram_wr = 1; dma_sdram_rd = 0;
                    dma_sdram_addr_x16 = 24'h00ABCD; dma_sdram_wdata = 16'h5A5A; dma_sdram_wmask = 2'b01;
                    dma_on_last = 0;
                end
                sdram_rdy = 1;
                sdram_rdata = d;
                #1;
                chk("rdy_route", 32'({video_sdram_rdy, cpu_sdram_rdy, dma_sdram_rdy}), 32'(own_vec(exp)));
                chk("rdata", 32'(exp == 2'd1 ? video_sdram_rdata : exp == 2'd2 ? cpu_sdram_rdata : dma_sdram_rdata), 32'(d));
                @(posedge clk_i);
                #1;
                sdram_rdy = 0;
                @(negedge clk_i);
            end
        end
        if (stop_after < 0) begin
            chk("grant_idle", 32'(grant_o), 32'd0);
            if (exp != 2'd1) last_cd = int'(exp);
        end
    endtask

    initial begin
        logic [1:0] exp;
        dma_on_last = 0;
        rst_n_i = 0;
        clear_inputs();
        last_cd = 3;
        #12;
        check_zero("reset");
        @(negedge clk_i);
        rst_n_i = 1;
        @(negedge clk_i);
        check_zero("post_reset");

        // CPU read alone
        cpu_sdram_rd = 1; cpu_sdram_addr_x16 = 24'h000100; cpu_sdram_wmask = 2'b11;
        beat_q.push_back(16'hBEEF);
        serve(2'd2, -1);
        chk("cpu_lat", 32'(lat), 32'd0);

        // Video burst
        video_sdram_rd = 1; video_sdram_addr_x16 = 24'h010000;
        beat_q.push_back(16'h1111); beat_q.push_back(16'h2222);
        beat_q.push_back(16'h3333); beat_q.push_back(16'h4444);
        serve(2'd1, -1);

        // CPU and DMA writes back to back: strict alternation from reset
        do_reset();
        cpu_sdram_wr = 1; cpu_sdram_addr_x16 = 24'h000200; cpu_sdram_wdata = 16'hC000; cpu_sdram_wmask = 2'b10;
        dma_sdram_wr = 1; dma_sdram_addr_x16 = 24'h000300; dma_sdram_wdata = 16'hD000; dma_sdram_wmask = 2'b01;
        for (int i = 0; i < 6; i++) begin
            exp = i % 2 == 0 ? 2'd2 : 2'd3;
            serve(exp, -1);
            chk("wr_lat", 32'(lat), 32'd0);
            if (exp == 2'd2) begin cpu_sdram_wr = 1; cpu_sdram_wdata = 16'hC001 + 16'(i); end
            else begin dma_sdram_wr = 1; dma_sdram_wdata = 16'hD001 + 16'(i); end
        end
        serve(2'd2, -1);
        serve(2'd3, -1);

        // All three at once
        video_sdram_rd = 1; video_sdram_addr_x16 = 24'h030000;
        cpu_sdram_wr = 1; cpu_sdram_addr_x16 = 24'h000400; cpu_sdram_wdata = 16'hCAFE; cpu_sdram_wmask = 2'b11;
        dma_sdram_wr = 1; dma_sdram_addr_x16 = 24'h000500; dma_sdram_wdata = 16'hF00D; dma_sdram_wmask = 2'b11;
        serve(2'd1, -1);
        serve(2'd2, -1);
        serve(2'd3, -1);

        // Reset in the middle of a video drain
        video_sdram_rd = 1; video_sdram_addr_x16 = 24'h020000;
        serve(2'd1, 2);
        chk("drain_grant", 32'(grant_o), 32'd1);
        rst_n_i = 0;
        clear_inputs();
        #1;
        check_zero("mid_reset");
        @(negedge clk_i);
        rst_n_i = 1;
        last_cd = 3;
        @(negedge clk_i);
        cpu_sdram_rd = 1; cpu_sdram_addr_x16 = 24'h000600;
        serve(2'd2, -1);
        chk("after_rst_lat", 32'(lat), 32'd0);

        // DMA request arrives with the last beat
        dma_on_last = 1;
        cpu_sdram_rd = 1; cpu_sdram_addr_x16 = 24'h000700;
        serve(2'd2, -1);
        chk("gap_idle_wr", 32'(sdram_wr), 32'd0);
        serve(2'd3, -1);
        chk("gap_lat", 32'(lat), 32'd0);

        // Random traffic against the priority/round-robin rules
        for (int t = 0; t < 60; t++) begin
            if (!video_sdram_rd && $urandom_range(0, 3) == 0) begin
                video_sdram_rd = 1;
                video_sdram_addr_x16 = 24'($urandom);
            end
            if (!(cpu_sdram_rd || cpu_sdram_wr) && $urandom_range(0, 1) == 1) raise_cpu();
            if (!(dma_sdram_rd || dma_sdram_wr) && $urandom_range(0, 1) == 1) raise_dma();
            if (!(video_sdram_rd || cpu_sdram_rd || cpu_sdram_wr || dma_sdram_rd || dma_sdram_wr)) raise_cpu();
            if (video_sdram_rd) exp = 2'd1;
            else if ((cpu_sdram_rd || cpu_sdram_wr) && (dma_sdram_rd || dma_sdram_wr)) exp = last_cd == 2 ? 2'd3 : 2'd2;
            else if (cpu_sdram_rd || cpu_sdram_wr) exp = 2'd2;
            else exp = 2'd3;
            serve(exp, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
